// File: rtl/div_seq_nbit_if.sv
// div_seq_nbit_if: operand/result bundle with start/busy/done handshake for div_seq_nbit
interface div_seq_nbit_if #(parameter int WIDTH = 4);
   logic start, busy, done, div_err;
   logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
   modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_err);
   modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_err);
endinterface

// File: rtl/div_seq_nbit.sv
// div_seq_nbit: sequential unsigned restoring divider, one quotient bit per cycle.
// DIV_ZERO_DETECT_EN: zero divisor skips RUN and raises div_err with the result.
module div_seq_nbit #(parameter int WIDTH = 4) (
   input logic clk,
   input logic rst,
   div_seq_nbit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] rem, dvd, dsr, quo, rmd, rem_nx, dvd_nx, diff;
   logic [WIDTH:0] shifted;
   logic ge, accept, zero;
`ifdef DIV_ZERO_DETECT_EN
   logic err;
   assign zero = bus.divisor == '0;
   assign bus.div_err = err;
   always_ff @(posedge clk or posedge rst)
      if (rst) err <= 1'b0;
      else if (accept) err <= zero;
`else
   assign zero = 1'b0;
   assign bus.div_err = 1'b0;
`endif
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.quotient = quo;
   assign bus.remainder = rmd;
   // ge is the WIDTH+1-bit trial compare; when it holds the true difference fits WIDTH bits
   always_comb begin
      accept = bus.start && state != RUN;
      shifted = {rem, dvd[WIDTH-1]};
      ge = shifted >= {1'b0, dsr};
      diff = shifted[WIDTH-1:0] - dsr;
      rem_nx = ge ? diff : shifted[WIDTH-1:0];
      dvd_nx = {dvd[WIDTH-2:0], ge};
      state_nx = state;
      if (accept) state_nx = zero ? DONE : RUN;
      else if (state == RUN && cnt == '0) state_nx = DONE;
      else if (state == DONE) state_nx = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         rem <= '0;
         dvd <= '0;
         dsr <= '0;
         quo <= '0;
         rmd <= '0;
      end else if (accept) begin
         cnt <= CW'(WIDTH - 1);
         rem <= '0;
         dvd <= bus.dividend;
         dsr <= bus.divisor;
         if (zero) begin
            quo <= '1;
            rmd <= bus.dividend;
         end
      end else if (state == RUN) begin
         cnt <= cnt - 1'b1;
         rem <= rem_nx;
         dvd <= dvd_nx;
         if (cnt == '0) begin
            quo <= dvd_nx;
            rmd <= rem_nx;
         end
      end
endmodule

// File: tb/tb_div_seq_nbit.sv
// tb_div_seq_nbit: directed + exhaustive + random stimulus, scoreboard checked by a done monitor
module tb_div_seq_nbit;
   localparam int W = 4;
`ifdef DIV_ZERO_DETECT_EN
   localparam bit ZD = 1'b1;
`else
   localparam bit ZD = 1'b0;
`endif
   typedef struct {int a; int b; int q; int r; int e; int t0; int lat;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int compared = 0;
   int mismatched = 0;
   int held_q = 0;
   int held_r = 0;
   exp_t sb[$];
   exp_t x;
   div_seq_nbit_if #(.WIDTH(W)) bus();
   div_seq_nbit #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string nm, int act, int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask
   function automatic exp_t model(int a, int b, int t0);
      exp_t m;
      m.a = a;
      m.b = b;
      m.q = (b == 0) ? (1 << W) - 1 : a / b;
      m.r = (b == 0) ? a : a % b;
      m.e = (b == 0 && ZD) ? 1 : 0;
      m.lat = (b == 0 && ZD) ? 1 : W;
      m.t0 = t0;
      return m;
   endfunction
   always @(negedge clk) begin
      if (rst) begin
         held_q = 0;
         held_r = 0;
         sb.delete();
      end else begin
         if (bus.busy && bus.done) chk("busy_and_done", 1, 0);
         if (bus.done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               x = sb.pop_front();
               chk("quotient", int'(bus.quotient), x.q);
               chk("remainder", int'(bus.remainder), x.r);
               chk("div_err", int'(bus.div_err), x.e);
               chk("latency", cyc - x.t0, x.lat);
               if (x.b != 0) begin
                  chk("q*d+r==n", int'(bus.quotient) * x.b + int'(bus.remainder), x.a);
                  chk("r<d", int'(int'(bus.remainder) < x.b), 1);
               end
            end
            held_q = int'(bus.quotient);
            held_r = int'(bus.remainder);
         end else begin
            chk("hold_quotient", int'(bus.quotient), held_q);
            chk("hold_remainder", int'(bus.remainder), held_r);
         end
      end
   end
   task automatic issue(int a, int b);
      bus.start = 1'b1;
      bus.dividend = a[W-1:0];
      bus.divisor = b[W-1:0];
      @(posedge clk);
      #1;
      sb.push_back(model(a, b, cyc));
      bus.start = 1'b0;
   endtask
   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) return;
      end
      chk("done_timeout", 0, 1);
   endtask
   task automatic busy_run(int a, int b, int expb);
      int n = 0;
      bit seen = 1'b0;
      issue(a, b);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
         else if (bus.busy) n++;
      end
      chk("done_seen", int'(seen), 1);
      chk("busy_cycles", n, expb);
   endtask
   task automatic chk_zero(string nm);
      chk({nm, "_busy"}, int'(bus.busy), 0);
      chk({nm, "_done"}, int'(bus.done), 0);
      chk({nm, "_quotient"}, int'(bus.quotient), 0);
      chk({nm, "_remainder"}, int'(bus.remainder), 0);
      chk({nm, "_div_err"}, int'(bus.div_err), 0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      busy_run(11, 3, W);
      issue(13, 2);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("abort");
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (10) @(negedge clk);
      issue(15, 1);
      wait_done();
      issue(2, 5);
      wait_done();
      @(negedge clk);
      issue(9, 4);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dividend = 4'd7;
      bus.divisor = 4'd7;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      @(negedge clk);
      busy_run(6, 0, ZD ? 0 : W);
      @(negedge clk);
      for (int a = 0; a < 16; a++)
         for (int b = 1; b < 16; b++) begin
            issue(a, b);
            wait_done();
         end
      for (int i = 0; i < 150; i++) begin
         issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
